// File: rtl/copro_pkg.sv
// Shared types for the coprocessor dispatcher and the coprocessor itself:
// op encoding, dispatcher FSM states and default datapath widths.
package copro_pkg;

   localparam int W_DEF    = 8;
   localparam int RD_W_DEF = 5;

   typedef enum logic {
      OP_GCD = 1'b0,
      OP_LCM = 1'b1
   } op_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      WB    = 3'd3,
      DRAIN = 3'd4
   } state_t;

endpackage

// File: rtl/copro_dispatch.sv
// Issues one GCD/LCM request to the coprocessor over a four-phase start/done
// handshake and returns the result as a writeback. Option: COPRO_TIMEOUT_EN.
module copro_dispatch
   import copro_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int RD_W = RD_W_DEF
`ifdef COPRO_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 255
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [W-1:0]    req_a,
   input  logic [W-1:0]    req_b,
   input  logic            req_op,
   input  logic [RD_W-1:0] req_rd,
   output logic            stall,
   output logic            cp_start,
   output logic [W-1:0]    cp_x0,
   output logic [W-1:0]    cp_y0,
   output logic            cp_op,
   input  logic            cp_done,
   input  logic [W-1:0]    cp_result,
   output logic            wb_valid,
   output logic [RD_W-1:0] wb_rd,
   output logic [W-1:0]    wb_data,
   output logic            err,
   output state_t          state_dbg
);

   // Request handshake: a request transfers on a rising edge where
   // req_valid && req_ready; req_ready is high only in IDLE, so a request
   // presented in any other state is dropped, never queued.

   state_t          state, state_nxt;
   logic [RD_W-1:0] rd_q;
   logic            finish;

   assign req_ready = (state == IDLE);
   assign stall     = (state != IDLE) | req_valid;
   assign state_dbg = state;
   assign finish    = (state == WAIT) && (state_nxt == WB);

`ifdef COPRO_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;
   logic          expired;

   assign expired = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
         // Sticky: only reset clears it.
         if (finish && !cp_done) err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (req_valid) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
`ifdef COPRO_TIMEOUT_EN
         WAIT:  if (cp_done || expired) state_nxt = WB;
`else
         WAIT:  if (cp_done) state_nxt = WB;
`endif
         WB:    state_nxt = DRAIN;
         // Hold off the next start until the coprocessor has dropped done.
         DRAIN: if (!cp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cp_start <= 1'b0;
         cp_x0    <= '0;
         cp_y0    <= '0;
         cp_op    <= 1'b0;
         rd_q     <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
      end else begin
         state    <= state_nxt;
         cp_start <= (state_nxt == ISSUE) || (state_nxt == WAIT);
         wb_valid <= (state_nxt == WB);
         if (state == IDLE && req_valid) begin
            cp_x0 <= req_a;
            cp_y0 <= req_b;
            cp_op <= req_op;
            rd_q  <= req_rd;
         end
         // Leaving WAIT without done can only be a timeout: write back zero.
         if (finish) begin
            wb_rd   <= rd_q;
            wb_data <= cp_done ? cp_result : '0;
         end
      end
   end

endmodule

// File: tb/tb_copro_dispatch.sv
// Directed bench for copro_dispatch with a behavioural coprocessor and a
// transaction-level scoreboard; also exercises COPRO_TIMEOUT_EN when defined.
module tb_copro_dispatch;
   import copro_pkg::*;

   localparam int W    = 8;
   localparam int RD_W = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [W-1:0]    req_a = '0;
   logic [W-1:0]    req_b = '0;
   logic            req_op = 1'b0;
   logic [RD_W-1:0] req_rd = '0;
   logic            stall;
   logic            cp_start;
   logic [W-1:0]    cp_x0, cp_y0;
   logic            cp_op;
   logic            cp_done = 1'b0;
   logic [W-1:0]    cp_result = '0;
   logic            wb_valid;
   logic [RD_W-1:0] wb_rd;
   logic [W-1:0]    wb_data;
   logic            err;
   state_t          state_dbg;

   copro_dispatch #(
      .W(W),
      .RD_W(RD_W)
`ifdef COPRO_TIMEOUT_EN
      , .TIMEOUT(10)
`endif
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rd(req_rd),
      .stall(stall),
      .cp_start(cp_start), .cp_x0(cp_x0), .cp_y0(cp_y0), .cp_op(cp_op),
      .cp_done(cp_done), .cp_result(cp_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .err(err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
      int x, y, t;
      x = int'(a);
      y = int'(b);
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      if (op) return W'((int'(a) * int'(b)) / x);
      return W'(x);
   endfunction

   // Coprocessor model knobs
   int   cp_lat   = 3;
   int   cp_hold  = 0;
   logic cp_never = 1'b0;

   initial begin : coproc
      logic          st, os, busy;
      logic [W-1:0]  xs, ys, res;
      int            cnt, hold;
      busy = 1'b0; cnt = 0; hold = 0; res = '0;
      forever begin
         @(negedge clk);
         st = cp_start; xs = cp_x0; ys = cp_y0; os = cp_op;
         @(posedge clk);
         #1;
         if (!reset) begin
            busy = 1'b0;
            cp_done = 1'b0;
         end else if (busy) begin
            if (cnt == 0) begin
               cp_done = 1'b1; cp_result = res; busy = 1'b0; hold = cp_hold;
            end else cnt--;
         end else if (cp_done) begin
            if (!st) begin
               if (hold == 0) cp_done = 1'b0;
               else hold--;
            end
         end else if (st && !cp_never) begin
            res = ref_fn(xs, ys, os);
            if (cp_lat == 0) begin
               cp_done = 1'b1; cp_result = res; hold = cp_hold;
            end else begin
               busy = 1'b1; cnt = cp_lat - 1;
            end
         end
      end
   end

   // Scoreboard and per-cycle protocol checks
   logic [RD_W+W-1:0] exp_q[$];
   logic              exp_timeout = 1'b0;
   int                n_wb = 0;
   int                cyc = 0;
   int                t_wb = 0;
   logic [RD_W-1:0]   last_rd = '0;
   logic [W-1:0]      last_data = '0;

   initial begin : monitor
      logic            p_acc, p_start, p_done, p_wb;
      logic [W-1:0]    cur_a, cur_b;
      logic            cur_op;
      logic [RD_W+W-1:0] e;
      p_acc = 0; p_start = 0; p_done = 0; p_wb = 0;
      cur_a = '0; cur_b = '0; cur_op = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            p_acc = 0; p_start = 0; p_done = 0; p_wb = 0;
         end else begin
            if (p_acc) check("start_after_accept", cp_start, 1);
            if (p_start && p_done) begin
               check("wb_after_done", wb_valid, 1);
               check("start_drop_after_done", cp_start, 0);
            end
            if (cp_start && !p_start) check("no_start_while_done", cp_done, 0);
            if (p_wb) check("wb_one_cycle", wb_valid, 0);
            check("stall_rule", stall, !req_ready || req_valid);
            if (cp_start) begin
               check("cp_x0_stable", cp_x0, cur_a);
               check("cp_y0_stable", cp_y0, cur_b);
               check("cp_op_stable", cp_op, cur_op);
            end
`ifndef COPRO_TIMEOUT_EN
            check("err_zero", err, 0);
`endif
            if (wb_valid) begin
               if (exp_q.size() == 0) check("wb_unexpected", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("wb_rd", wb_rd, e[RD_W+W-1:W]);
                  check("wb_data", wb_data, e[W-1:0]);
               end
               n_wb++;
               last_rd = wb_rd;
               last_data = wb_data;
               t_wb = cyc;
            end
            if (req_valid && req_ready) begin
               cur_a = req_a; cur_b = req_b; cur_op = req_op;
               exp_q.push_back({req_rd, exp_timeout ? {W{1'b0}} : ref_fn(req_a, req_b, req_op)});
            end
            p_acc = req_valid && req_ready;
            p_start = cp_start;
            p_done = cp_done;
            p_wb = wb_valid;
         end
      end
   end

   task automatic do_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         input logic [RD_W-1:0] rd);
      int k = 0;
      @(posedge clk); #1;
      while (!req_ready && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      check("req_ready_seen", req_ready, 1);
      req_a = a; req_b = b; req_op = op; req_rd = rd; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_wb(input int budget);
      int start = n_wb;
      int k = 0;
      while (n_wb == start && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check("wb_seen", n_wb != start, 1);
   endtask

   task automatic wait_ready(input int budget);
      int k = 0;
      while (!req_ready && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check("ready_return", req_ready, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench timeout");
   end

   initial begin : directed
      int n0, t0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_state", state_dbg, IDLE);
      #2 reset = 1'b1;
      @(negedge clk); #1;
      check("rel_req_ready", req_ready, 1);
      check("rel_cp_start", cp_start, 0);
      check("rel_wb_valid", wb_valid, 0);
      check("rel_stall", stall, 0);
      check("rel_err", err, 0);
      check("rel_cp_x0", cp_x0, 0);
      check("rel_wb_data", wb_data, 0);

      // GCD(12,18) -> 6
      cp_lat = 3;
      do_req(8'd12, 8'd18, OP_GCD, 5'd5);
      check("issue_start", cp_start, 1);
      wait_wb(50);
      check("gcd_rd_lit", last_rd, 5);
      check("gcd_data_lit", last_data, 6);
      wait_ready(20);

      // LCM(4,6) -> 12, with an ignored request during WAIT
      cp_lat = 5;
      n0 = n_wb;
      do_req(8'd4, 8'd6, OP_LCM, 5'd3);
      @(posedge clk); #1;
      req_a = 8'd99; req_b = 8'd33; req_op = 1'b0; req_rd = 5'd7; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_wb(50);
      repeat (8) @(negedge clk);
      #1;
      check("lcm_one_wb", n_wb - n0, 1);
      check("lcm_data_lit", last_data, 12);
      check("lcm_rd_lit", last_rd, 3);

      // Zero-latency coprocessor: done on first WAIT cycle; ready 2 cycles after wb
      cp_lat = 0;
      do_req(8'd16, 8'd24, OP_LCM, 5'd30);
      wait_wb(50);
      t0 = t_wb;
      wait_ready(20);
      check("lcm2_data_lit", last_data, 48);
      check("ready_after_wb", cyc - t0, 2);

      // Done held after start drops: DRAIN lasts until done falls
      cp_lat = 2;
      cp_hold = 4;
      do_req(8'd7, 8'd5, OP_GCD, 5'd9);
      wait_wb(50);
      t0 = t_wb;
      wait_ready(40);
      check("drain_len", cyc - t0, 6);
      check("gcd2_data_lit", last_data, 1);
      cp_hold = 0;

      // Reset asserted mid-WAIT abandons the operation
      cp_lat = 20;
      n0 = n_wb;
      do_req(8'd50, 8'd20, OP_GCD, 5'd2);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_req_ready", req_ready, 1);
      check("mid_rst_cp_start", cp_start, 0);
      check("mid_rst_wb_valid", wb_valid, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_cp_x0", cp_x0, 0);
      check("mid_rst_state", state_dbg, IDLE);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      cp_lat = 2;
      do_req(8'd255, 8'd85, OP_GCD, 5'd31);
      wait_wb(50);
      check("post_rst_data_lit", last_data, 85);
      check("post_rst_rd_lit", last_rd, 31);
      check("aborted_no_wb", n_wb - n0, 1);
      wait_ready(20);

`ifdef COPRO_TIMEOUT_EN
      // Coprocessor never answers: timeout writes back zero and sets err
      cp_never = 1'b1;
      exp_timeout = 1'b1;
      do_req(8'd9, 8'd6, OP_GCD, 5'd4);
      wait_wb(40);
      check("to_data_lit", last_data, 0);
      check("to_rd_lit", last_rd, 4);
      check("to_err", err, 1);
      exp_timeout = 1'b0;
      cp_never = 1'b0;
      wait_ready(20);
      do_req(8'd16, 8'd24, OP_LCM, 5'd1);
      wait_wb(50);
      check("after_to_data_lit", last_data, 48);
      check("err_sticky", err, 1);
`else
      check("err_default_zero", err, 0);
`endif

      repeat (5) @(negedge clk);
      check("exp_q_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/copro_dispatch.md
# copro_dispatch

Initiator side of the coprocessor start/Done handshake. It accepts one GCD/LCM request from the RISC-V execute stage and drives the coprocessor's `x0`/`y0`/`Op`/`start` inputs. It waits for `Done`, captures `result`, and returns it as a register-file writeback, holding the pipeline stalled throughout. It sits between the execute stage and the Coprocessor instance; the coprocessor is never driven directly by the pipeline.

## Interface
- `W`, 8: operand/result width; must match the coprocessor.
- `RD_W`, 5: destination register index width.
- `TIMEOUT`, 255: maximum cycles to wait for `cp_done` (only with `COPRO_TIMEOUT_EN`); ≥ 1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute stage presents a coprocessor instruction.
- `req_ready`  out  1  dispatcher can accept (`state==IDLE`).
- `req_a`, `req_b`  in  W  operand values (rs1, rs2).
- `req_op`  in  1  0 = GCD, 1 = LCM.
- `req_rd`  in  RD_W  destination register.
- `stall`  out  1  freeze upstream pipeline.
- `cp_start`  out  1  to Coprocessor `start`.
- `cp_x0`, `cp_y0`  out  W  to Coprocessor `x0`/`y0`.
- `cp_op`  out  1  to Coprocessor `Op`.
- `cp_done`  in  1  from Coprocessor `Done`.
- `cp_result`  in  W  from Coprocessor `result`.
- `wb_valid`  out  1  one-cycle writeback strobe.
- `wb_rd`  out  RD_W  writeback register.
- `wb_data`  out  W  writeback value.
- `err`  out  1  sticky timeout flag (`COPRO_TIMEOUT_EN` only; otherwise tied 0).

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE: `req_ready`=1. When `req_valid`=1, latch a/b/op/rd into `cp_x0`/`cp_y0`/`cp_op`/rd register, then go to ISSUE.
- ISSUE: assert `cp_start`, then go to WAIT.
- WAIT: hold `cp_start`=1 and hold all operands stable. When `cp_done`=1, latch `cp_result`, deassert `cp_start`, and go to WB.
- WB: `wb_valid`=1 for exactly one cycle, with `wb_rd`/`wb_data` from the latches. Then go to DRAIN.
- DRAIN: wait for `cp_done`=0, then go to IDLE. This makes the protocol four-phase; a new `cp_start` is never raised while `cp_done` is still high.
- `stall`=1 in every state except IDLE. Also `stall`=1 in the IDLE cycle where `req_valid`=1 is accepted.
- `cp_done`=1 in IDLE or ISSUE is ignored. In WAIT it completes the operation even if it is the first WAIT cycle.
- `req_valid` outside IDLE is ignored; nothing is queued.
- Operands and result pass through unmodified, with no width conversion. `wb_data` equals `cp_result` exactly as sampled.
- Reset, asynchronous at any state: go to IDLE. All outputs are 0 except `req_ready`=1. Latches are cleared, `err`=0, and an in-flight operation is abandoned.

## Timing
- Accept edge → `cp_start` high the next cycle (ISSUE).
- `cp_done` sampled high at edge N → `wb_valid` high in cycle N+1. `cp_start` is low from N+1.
- Minimum request-to-writeback latency is 3 cycles plus the coprocessor latency.
- With `cp_done` already low at WB exit, `req_ready` returns 1 two cycles after `wb_valid`.
- All outputs are registered except `req_ready` and `stall`, which decode state (and `req_valid`).

## Configuration
- `COPRO_TIMEOUT_EN` defined:
  - A cycle counter of width `$clog2(TIMEOUT+1)` runs in WAIT.
  - If it reaches `TIMEOUT` without `cp_done`, drop `cp_start`, set `err`, and emit `wb_valid` with `wb_data`=0.
  - Then proceed to DRAIN.
  - `err` is cleared only by reset.
- Not defined: no counter; WAIT can last indefinitely; `err` is constant 0.

## Structure
- Shared package `copro_pkg`:
  - op encoding enum (`OP_GCD`=0, `OP_LCM`=1).
  - FSM state enum.
  - default `W`/`RD_W` constants.
- The Coprocessor instance is also to import `copro_pkg`.
- Single module; no sub-module needed. The timeout counter stays inline under the macro.

## Test plan
- Reset held low, then released → `req_ready`=1, `cp_start`=0, `wb_valid`=0, `stall`=0.
- req a=12, b=18, op=0, rd=5 with real Coprocessor → one `wb_valid` pulse, `wb_rd`=5, `wb_data`=6. `cp_start` high from ISSUE until `cp_done`.
- req a=4, b=6, op=1, rd=3 → `wb_data`=12. Second `req_valid` pulsed during WAIT → ignored; exactly one writeback.
- Model holds `cp_done` high 4 cycles after result → DRAIN persists those cycles. Next `cp_start` only after `cp_done`=0.
- `reset` asserted mid-WAIT → outputs return to reset values immediately. A fresh request afterwards completes normally.
- With `COPRO_TIMEOUT_EN` and `TIMEOUT`=10, model never asserts `cp_done` → `wb_valid` with `wb_data`=0 and `err`=1. `err` stays 1 after later requests succeed.
